// File: rtl/soc_uart_loader.sv
// soc_uart_loader
//   UART-driven bus master / boot loader. Decodes word read/write commands
//   from a received byte stream, drives the interconnect stb/ack master port
//   while the CPU is held in reset, and returns replies as a byte stream.
//
// Ports
//   clk, RST_N                 clock, synchronous active-low reset
//   i_rx_data/i_rx_valid       received byte stream
//   o_rx_ready                 loader accepts a byte (valid && ready)
//   o_tx_data/o_tx_valid       reply byte stream
//   i_tx_ready                 transmitter accepts the byte
//   o_addr/o_rw/o_dtw/o_stb    bus request (o_rw=1 is a write)
//   i_dtr/i_ack                bus read data and single-cycle acknowledge
//   o_hold                     CPU reset / loader owns the interconnect
//
// Commands: 'W' addr[4] data[4], 'R' addr[4], 'w' data[4] (addr += 4),
//   'H' hold, 'G' release. Replies: 4B ok, 3F unknown, 45 bus command
//   while released, 21 ack timeout, or 4 read-data bytes MSB first.
module soc_uart_loader #(
  parameter bit HOLD_ON_RESET = 1'b1,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_addr,
  output logic        o_rw,
  output logic [31:0] o_dtw,
  input  logic [31:0] i_dtr,
  output logic        o_stb,
  input  logic        i_ack,
  output logic        o_hold
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  // Value of the timeout counter in the last cycle o_stb may stay high.
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [7:0] C_WRITE = 8'h57;
  localparam logic [7:0] C_READ  = 8'h52;
  localparam logic [7:0] C_WNEXT = 8'h77;
  localparam logic [7:0] C_HOLD  = 8'h48;
  localparam logic [7:0] C_GO    = 8'h47;

  localparam logic [7:0] R_OK   = 8'h4B;
  localparam logic [7:0] R_UNK  = 8'h3F;
  localparam logic [7:0] R_FREE = 8'h45;
  localparam logic [7:0] R_TMO  = 8'h21;

  logic [2:0]    state;
  logic          is_wr;
  logic [1:0]    bcnt;      // payload byte index, or reply bytes remaining
  logic [TW-1:0] tcnt;
  logic [23:0]   resp_buf;  // remaining read-reply bytes, next in [23:16]

  logic       rx_fire;
  logic       launch;
  logic       idle_bus_cmd;
  logic [7:0] idle_reply;

  assign rx_fire = i_rx_valid & o_rx_ready;

  // Final payload byte of a bus command: 4th address byte of a read or
  // 4th data byte of a write.
  assign launch = rx_fire && (bcnt == 2'd3) &&
                  ((state == S_DATA) || ((state == S_ADDR) && !is_wr));

  always_comb begin
    idle_bus_cmd = 1'b0;
    idle_reply   = R_UNK;
    case (i_rx_data)
      C_WRITE, C_READ, C_WNEXT: idle_bus_cmd = 1'b1;
      C_HOLD, C_GO:             idle_reply   = R_OK;
      default:                  idle_reply   = R_UNK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      is_wr      <= 1'b0;
      bcnt       <= 2'd0;
      tcnt       <= '0;
      o_hold     <= HOLD_ON_RESET;
      o_stb      <= 1'b0;
      o_rw       <= 1'b0;
      o_addr     <= 32'd0;
      o_dtw      <= 32'd0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'd0;
      o_rx_ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            bcnt <= 2'd0;
            if (idle_bus_cmd) begin
              is_wr <= (i_rx_data != C_READ);
              if (i_rx_data == C_WNEXT) begin
                o_addr <= o_addr + 32'd4;
                state  <= S_DATA;
              end else begin
                state  <= S_ADDR;
              end
            end else begin
              if (i_rx_data == C_HOLD) o_hold <= 1'b1;
              if (i_rx_data == C_GO)   o_hold <= 1'b0;
              state      <= S_RESP;
              o_rx_ready <= 1'b0;
              o_tx_valid <= 1'b1;
              o_tx_data  <= idle_reply;
            end
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            o_addr <= {o_addr[23:0], i_rx_data};
            bcnt   <= bcnt + 2'd1;
            if ((bcnt == 2'd3) && is_wr) state <= S_DATA;
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            o_dtw <= {o_dtw[23:0], i_rx_data};
            bcnt  <= bcnt + 2'd1;
          end
        end

        S_BUS: begin
          // An ack is checked before the timeout so that an ack in the
          // final counted cycle still completes the access.
          if (i_ack) begin
            o_stb      <= 1'b0;
            o_tx_valid <= 1'b1;
            state      <= S_RESP;
            if (o_rw) begin
              o_tx_data <= R_OK;
              bcnt      <= 2'd0;
            end else begin
              o_tx_data <= i_dtr[31:24];
              resp_buf  <= i_dtr[23:0];
              bcnt      <= 2'd3;
            end
          end else if (tcnt == T_LAST) begin
            o_stb      <= 1'b0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= R_TMO;
            bcnt       <= 2'd0;
            state      <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_RESP: begin
          // o_tx_valid is always high here; hold o_tx_data until taken.
          if (i_tx_ready) begin
            if (bcnt == 2'd0) begin
              o_tx_valid <= 1'b0;
              o_rx_ready <= 1'b1;
              state      <= S_IDLE;
            end else begin
              bcnt      <= bcnt - 2'd1;
              o_tx_data <= resp_buf[23:16];
              resp_buf  <= {resp_buf[15:0], 8'h00};
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          o_stb      <= 1'b0;
          o_tx_valid <= 1'b0;
          o_rx_ready <= 1'b1;
        end
      endcase

      // Payload complete: issue the bus access, or refuse it when the CPU
      // has been released and owns the interconnect.
      if (launch) begin
        o_rx_ready <= 1'b0;
        if (o_hold) begin
          state <= S_BUS;
          o_stb <= 1'b1;
          o_rw  <= is_wr;
          tcnt  <= '0;
        end else begin
          state      <= S_RESP;
          o_tx_valid <= 1'b1;
          o_tx_data  <= R_FREE;
          bcnt       <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_uart_loader.sv
// tb_soc_uart_loader
//   Directed bench for soc_uart_loader (ACK_TIMEOUT=4). Reply bytes are
//   pushed to a queue as each command is driven and popped by a monitor
//   whenever the DUT hands a byte to the transmitter.
module tb_soc_uart_loader;

  logic        clk = 1'b0;
  logic        RST_N;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_addr;
  logic        o_rw;
  logic [31:0] o_dtw;
  logic [31:0] i_dtr;
  logic        o_stb;
  logic        i_ack;
  logic        o_hold;

  always #5 clk = ~clk;

  soc_uart_loader #(
    .HOLD_ON_RESET(1'b1),
    .ACK_TIMEOUT  (4)
  ) dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_addr    (o_addr),
    .o_rw      (o_rw),
    .o_dtw     (o_dtw),
    .i_dtr     (i_dtr),
    .o_stb     (o_stb),
    .i_ack     (i_ack),
    .o_hold    (o_hold)
  );

  int         total = 0;
  int         bad = 0;
  int         stb_cycles = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%08h want=%08h", tag, got, exp);
    end
  endtask

  task automatic push4(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Samples 2 time units after each falling edge, after the stimulus for
  // that edge has settled and well before the next rising edge.
  task automatic tx_monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (o_stb) stb_cycles++;
      if (RST_N && o_tx_valid && i_tx_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL tx_extra got=%02h want=none", o_tx_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(o_tx_data), 32'(e));
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 200) else begin
      bad++;
      $error("FAIL rx_ready_wait got=%0d want=<200", n);
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic check_launch(input logic [31:0] a, input logic [31:0] d,
                              input logic rw, input bit chk_d);
    chk("stb_rise", 32'(o_stb), 32'd1);
    chk("addr", o_addr, a);
    chk("rw", 32'(o_rw), 32'(rw));
    if (chk_d) chk("dtw", o_dtw, d);
  endtask

  // Ack in stb cycle 'cyc' (1 = first cycle o_stb is high).
  task automatic do_ack(input logic [31:0] dtr, input int cyc);
    for (int i = 1; i < cyc; i++) begin
      @(negedge clk);
      chk("stb_hold", 32'(o_stb), 32'd1);
    end
    i_ack = 1'b1;
    i_dtr = dtr;
    @(negedge clk);
    i_ack = 1'b0;
    i_dtr = 32'd0;
    chk("stb_drop", 32'(o_stb), 32'd0);
    chk("turnaround_txv", 32'(o_tx_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int s0;
    RST_N      = 1'b0;
    i_rx_data  = 8'd0;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    i_ack      = 1'b0;
    i_dtr      = 32'd0;
    fork
      tx_monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(o_hold), 32'd1);
    chk("rst_stb", 32'(o_stb), 32'd0);
    chk("rst_rw", 32'(o_rw), 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    chk("rst_dtw", o_dtw, 32'd0);
    chk("rst_txv", 32'(o_tx_valid), 32'd0);
    chk("rst_txd", 32'(o_tx_data), 32'd0);
    chk("rst_rxr", 32'(o_rx_ready), 32'd1);
    RST_N = 1'b1;
    @(negedge clk);

    // W 0x100 <- DEADBEEF, ack in third stb cycle
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h0000_0100);
    send_word(32'hDEAD_BEEF);
    check_launch(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b1);
    do_ack(32'd0, 3);
    drain();

    // w -> 0x104 <- CAFEBABE
    exp_q.push_back(8'h4B);
    send_byte(8'h77);
    send_word(32'hCAFE_BABE);
    check_launch(32'h0000_0104, 32'hCAFE_BABE, 1'b1, 1'b1);
    do_ack(32'd0, 3);
    drain();

    // R 0x100 -> 12345678 with the transmitter stalled 10 cycles
    push4(32'h1234_5678);
    send_byte(8'h52);
    send_word(32'h0000_0100);
    check_launch(32'h0000_0100, 32'd0, 1'b0, 1'b0);
    i_tx_ready = 1'b0;
    do_ack(32'h1234_5678, 3);
    for (int i = 0; i < 10; i++) begin
      chk("stall_txd", 32'(o_tx_data), 32'h12);
      chk("stall_txv", 32'(o_tx_valid), 32'd1);
      @(negedge clk);
    end
    i_tx_ready = 1'b1;
    drain();

    // Address wrap: W 0xFFFFFFFC then w lands on 0
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'hFFFF_FFFC);
    send_word(32'h1122_3344);
    check_launch(32'hFFFF_FFFC, 32'h1122_3344, 1'b1, 1'b1);
    do_ack(32'd0, 2);
    drain();
    exp_q.push_back(8'h4B);
    send_byte(8'h77);
    send_word(32'h5566_7788);
    check_launch(32'h0000_0000, 32'h5566_7788, 1'b1, 1'b1);
    do_ack(32'd0, 1);
    drain();

    // Timeout: R 0x200 with no ack
    exp_q.push_back(8'h21);
    send_byte(8'h52);
    send_word(32'h0000_0200);
    check_launch(32'h0000_0200, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (o_stb && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_stb_cycles", 32'(n), 32'd4);
    chk("tmo_txv", 32'(o_tx_valid), 32'd1);
    drain();
    chk("tmo_addr", o_addr, 32'h0000_0200);

    // Retry at the same address, acked in the final counted cycle
    push4(32'hA5A5_5A5A);
    send_byte(8'h52);
    send_word(32'h0000_0200);
    check_launch(32'h0000_0200, 32'd0, 1'b0, 1'b0);
    do_ack(32'hA5A5_5A5A, 4);
    drain();

    // Hold control
    exp_q.push_back(8'h4B);
    send_byte(8'h47);
    chk("g_hold", 32'(o_hold), 32'd0);
    drain();
    s0 = stb_cycles;
    exp_q.push_back(8'h45);
    send_byte(8'h57);
    send_word(32'h0000_0010);
    send_word(32'h0000_0001);
    chk("free_stb", 32'(o_stb), 32'd0);
    drain();
    chk("free_stb_cycles", 32'(stb_cycles - s0), 32'd0);
    exp_q.push_back(8'h4B);
    send_byte(8'h48);
    chk("h_hold", 32'(o_hold), 32'd1);
    drain();
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    drain();

    // Reset restores hold after a release
    exp_q.push_back(8'h4B);
    send_byte(8'h47);
    drain();
    chk("g2_hold", 32'(o_hold), 32'd0);
    RST_N = 1'b0;
    @(negedge clk);
    chk("rst2_hold", 32'(o_hold), 32'd1);
    RST_N = 1'b1;
    @(negedge clk);

    // Reset during BUS aborts the access
    send_byte(8'h57);
    send_word(32'h0000_0300);
    send_word(32'h0BAD_F00D);
    check_launch(32'h0000_0300, 32'h0BAD_F00D, 1'b1, 1'b1);
    @(negedge clk);
    RST_N = 1'b0;
    @(negedge clk);
    chk("abort_stb", 32'(o_stb), 32'd0);
    chk("abort_txv", 32'(o_tx_valid), 32'd0);
    chk("abort_rxr", 32'(o_rx_ready), 32'd1);
    chk("abort_hold", 32'(o_hold), 32'd1);
    chk("abort_addr", o_addr, 32'd0);
    RST_N = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    drain();
    repeat (3) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_uart_loader.md
# soc_uart_loader

UART-driven bus master and boot loader that sits upstream of the SoC memory interconnect, beside the CPU. It takes a byte stream from the UART receiver and decodes word read/write commands. It drives the interconnect's stb/ack master port while it holds the CPU in reset, so that firmware can be written into BRAM or external SRAM before the core is released. Responses return on a byte stream to the UART transmitter.

## Interface
- `HOLD_ON_RESET`, default 1: value of `o_hold` after reset (1 = CPU held, loader owns the bus).
- `ACK_TIMEOUT`, default 255: bus cycles to wait for `i_ack` before aborting; counter width is `$clog2(ACK_TIMEOUT+1)`.
- `clk` in 1: clock.
- `RST_N` in 1: reset, synchronous, active-low.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: `i_rx_data` valid.
- `o_rx_ready` out 1: loader accepts a byte; the transfer happens when valid && ready.
- `o_tx_data` out 8: response byte.
- `o_tx_valid` out 1: response byte valid.
- `i_tx_ready` in 1: transmitter accepts the byte.
- `o_addr` out 32: bus address.
- `o_rw` out 1: 1 = write.
- `o_dtw` out 32: write data.
- `i_dtr` in 32: read data, valid with `i_ack`.
- `o_stb` out 1: bus request.
- `i_ack` in 1: bus acknowledge (single-cycle).
- `o_hold` out 1: CPU reset/bus-select. The top ORs it into CPU reset and muxes the loader onto the interconnect when it is 1.

## Operation
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE: `o_rx_ready`=1. The accepted byte is the command.
  - 0x57 'W': go to ADDR, then DATA, then BUS with a write.
  - 0x52 'R': go to ADDR, then BUS with a read.
  - 0x77 'w': `addr += 4` (wrap mod 2^32), then DATA, then BUS with a write.
  - 0x48 'H': set hold=1, reply 0x4B.
  - 0x47 'G': set hold=0, reply 0x4B.
  - Any other byte: reply 0x3F.
- ADDR: collect 4 bytes, MSB first, into the address register. `o_rx_ready`=1.
- DATA: collect 4 bytes, MSB first, into the data register. `o_rx_ready`=1.
- Bus commands (W/R/w) issued while hold=0 do not touch the bus. The loader consumes their full payload, then replies 0x45.
- BUS: `o_stb`=1, with `o_addr`, `o_rw` and `o_dtw` stable until `i_ack`.
  - On `i_ack`: drop `o_stb` the next cycle and latch `i_dtr` for reads.
  - Write reply: 0x4B.
  - Read reply: 4 data bytes, MSB first.
  - After `ACK_TIMEOUT` cycles with no ack: drop `o_stb` and reply 0x21. The address register is unchanged.
- RESP: present reply bytes in order. Advance one byte per cycle where `o_tx_valid` && `i_tx_ready`. After the last byte, go to IDLE.
- `o_rx_ready`=0 in BUS and RESP. Bytes offered during these states are not consumed; upstream buffers them.
- The address register persists across commands. 'w' after 'W'/'R' at address A writes A+4.

## Timing
- Reset values: `o_hold`=`HOLD_ON_RESET`, `o_stb`=0, `o_rw`=0, `o_addr`=0, `o_dtw`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_rx_ready`=1, state=IDLE, byte counter=0, timeout counter=0.
- All outputs are registered.
- `o_stb` rises in the cycle after the last payload byte is accepted.
- Turnaround: the ack cycle A leads to `o_stb`=0 and `o_tx_valid`=1 at cycle A+1.
- `o_tx_data` is stable while `o_tx_valid` && !`i_tx_ready`.
- Command byte to `o_stb`:
  - 'W': 9 accepted bytes.
  - 'R': 5 accepted bytes.
  - 'w': 5 accepted bytes.
- Timeout: `o_stb` is high for exactly `ACK_TIMEOUT` cycles when no ack arrives. An ack in the final counted cycle is honoured as success.
- 'G' takes effect the cycle after acceptance. The 0x4B reply follows, so the CPU may start running while the reply is in flight.
- `RST_N` low mid-transaction aborts immediately: `o_stb`=0 and `o_tx_valid`=0 in the next cycle, and the partial command is discarded. `o_hold` returns to `HOLD_ON_RESET`.

## Test plan
- Bytes 57 00 00 01 00 DE AD BE EF:
  - `o_stb` rises with `o_addr`=0x00000100, `o_dtw`=0xDEADBEEF, `o_rw`=1.
  - Ack after 3 cycles.
  - Tx emits 4B.
- Bytes 52 00 00 01 00 with ack returning `i_dtr`=0x12345678: tx emits 12 34 56 78, `o_rw`=0.
- After W at 0x100, send 77 CA FE BA BE: write at 0x104 with data 0xCAFEBABE. Repeat at 0xFFFFFFFC: the next 'w' writes 0x00000000.
- `ACK_TIMEOUT`=4, no ack:
  - `o_stb` high exactly 4 cycles, tx emits 21.
  - A following R to the same address with ack succeeds.
- Hold control:
  - Reset gives `o_hold`=1.
  - 'G' gives `o_hold`=0, reply 4B.
  - W 0x10 00 00 00 01 gives no `o_stb`, reply 45.
  - 'H' gives `o_hold`=1, reply 4B.
  - Byte 0x00 gives reply 3F.
- Edge cases:
  - `i_tx_ready` held low 10 cycles during a read reply: byte 0x12 stays stable and no byte is lost.
  - `RST_N` pulled low during BUS: `o_stb`=0 next cycle and state IDLE.
